// File: rtl/pmu_pkg.sv
// Shared constants, state encoding and opcode helper for the PMU frame receiver.
package pmu_pkg;

    localparam int KEY_LENGTH    = 128;
    localparam int HEADER_LENGTH = 64;
    localparam int FRAME_LENGTH  = HEADER_LENGTH + KEY_LENGTH;

    localparam logic [3:0] OP_LOAD_KEY = 4'b0000;
    localparam logic [3:0] OP_LOAD_MEM = 4'b0001;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_SHORT   = 2'b01;
    localparam logic [1:0] ERR_OVERRUN = 2'b10;
    localparam logic [1:0] ERR_OPCODE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Only the two load commands are accepted by the downstream core.
    function automatic logic opcode_legal(input logic [3:0] op);
        return (op == OP_LOAD_KEY) || (op == OP_LOAD_MEM);
    endfunction

endpackage

// File: rtl/pmu_sipo.sv
// Serial-in / parallel-out frame register, LSB first, with a saturating bit counter.
// Bits arriving once the counter has reached the frame length are dropped.
module pmu_sipo #(
    parameter int FRAME_LEN = pmu_pkg::FRAME_LENGTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 shift_en,
    input  logic                 data_i,
    output logic [7:0]           cnt_o,
    output logic [FRAME_LEN-1:0] frame_o
);

    logic room;

    assign room = (cnt_o < 8'(FRAME_LEN));

    // Bit counter: cleared outside of a frame, saturates at the frame length.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_o <= 8'd0;
        end else if (clr) begin
            cnt_o <= 8'd0;
        end else if (shift_en && room) begin
            cnt_o <= cnt_o + 8'd1;
        end
    end

    // Frame storage: each accepted bit lands at the current counter index.
    always_ff @(posedge clk) begin
        if (!clr && shift_en && room) begin
            frame_o[cnt_o] <= data_i;
        end
    end

endmodule

// File: rtl/pmu_frame_rx.sv
// PMU frame receiver: collects a serial header+payload frame, checks the opcode,
// and holds the frame for the PMU core under a valid/ready handshake.
module pmu_frame_rx #(
    parameter int KEY_LENGTH    = pmu_pkg::KEY_LENGTH,
    parameter int HEADER_LENGTH = pmu_pkg::HEADER_LENGTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     data_i,
    input  logic                     frame_ready_i,
    output logic                     frame_valid_o,
    output logic [3:0]               opcode_o,
    output logic [HEADER_LENGTH-1:0] header_o,
    output logic [KEY_LENGTH-1:0]    payload_o,
    output logic                     err_o,
    output logic [1:0]               err_code_o,
    output logic                     busy_o
);

    import pmu_pkg::*;

    localparam int FRAME_LEN = HEADER_LENGTH + KEY_LENGTH;

    state_t               state;
    logic                 armed;
    logic                 en_q;
    logic [7:0]           cnt;
    logic [FRAME_LEN-1:0] frame;
    logic                 sipo_clr;
    logic                 sipo_shift;

    // The counter restarts whenever the receiver is not collecting bits.
    assign sipo_clr   = (state != ST_SHIFT);
    assign sipo_shift = (state == ST_SHIFT) && en;
    assign opcode_o   = header_o[3:0];

    pmu_sipo #(
        .FRAME_LEN (FRAME_LEN)
    ) u_sipo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (sipo_clr),
        .shift_en (sipo_shift),
        .data_i   (data_i),
        .cnt_o    (cnt),
        .frame_o  (frame)
    );

    // Frame FSM with registered outputs. After reset, en must be seen low once
    // (armed) so a frame cut by reset cannot be mistaken for a new one. An
    // overrun is reported once per rising en while a frame is held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            armed         <= 1'b0;
            en_q          <= 1'b0;
            frame_valid_o <= 1'b0;
            err_o         <= 1'b0;
            err_code_o    <= ERR_NONE;
            busy_o        <= 1'b0;
            header_o      <= '0;
            payload_o     <= '0;
        end else begin
            en_q  <= en;
            armed <= armed | ~en;
            err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en && armed) begin
                        state <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (en) begin
                        state  <= ST_SHIFT;
                        busy_o <= 1'b1;
                    end else begin
                        state      <= ST_IDLE;
                        err_o      <= 1'b1;
                        err_code_o <= ERR_SHORT;
                    end
                end
                ST_SHIFT: begin
                    if (!en) begin
                        if (cnt == 8'(FRAME_LEN)) begin
                            if (opcode_legal(frame[3:0])) begin
                                state         <= ST_HOLD;
                                frame_valid_o <= 1'b1;
                                header_o      <= frame[HEADER_LENGTH-1:0];
                                payload_o     <= frame[FRAME_LEN-1:HEADER_LENGTH];
                            end else begin
                                state      <= ST_IDLE;
                                busy_o     <= 1'b0;
                                err_o      <= 1'b1;
                                err_code_o <= ERR_OPCODE;
                            end
                        end else begin
                            state      <= ST_IDLE;
                            busy_o     <= 1'b0;
                            err_o      <= 1'b1;
                            err_code_o <= ERR_SHORT;
                        end
                    end
                end
                ST_HOLD: begin
                    if (frame_ready_i) begin
                        // Transfer edge; with en high it doubles as the next sync cycle.
                        frame_valid_o <= 1'b0;
                        busy_o        <= 1'b0;
                        state         <= en ? ST_SYNC : ST_IDLE;
                    end else if (en && !en_q) begin
                        err_o      <= 1'b1;
                        err_code_o <= ERR_OVERRUN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmu_frame_rx.sv
// Directed testbench for pmu_frame_rx.
module tb_pmu_frame_rx;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         data_i;
    logic         frame_ready_i;
    logic         frame_valid_o;
    logic [3:0]   opcode_o;
    logic [63:0]  header_o;
    logic [127:0] payload_o;
    logic         err_o;
    logic [1:0]   err_code_o;
    logic         busy_o;

    int total = 0;
    int bad = 0;
    int err_seen = 0;
    int valid_seen = 0;
    int xfer_seen = 0;

    pmu_frame_rx dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .data_i        (data_i),
        .frame_ready_i (frame_ready_i),
        .frame_valid_o (frame_valid_o),
        .opcode_o      (opcode_o),
        .header_o      (header_o),
        .payload_o     (payload_o),
        .err_o         (err_o),
        .err_code_o    (err_code_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    // Event counters sampled on the falling edge.
    always @(negedge clk) begin
        if (err_o === 1'b1) err_seen++;
        if (frame_valid_o === 1'b1) valid_seen++;
        if (frame_valid_o === 1'b1 && frame_ready_i === 1'b1) xfer_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // en high for the IDLE edge, the sync edge and nbits data edges; en left low.
    task automatic drive_frame(input logic [191:0] f, input int nbits);
        en = 1'b1;
        data_i = 1'b0;
        step();
        step();
        for (int i = 0; i < nbits; i++) begin
            data_i = f[i];
            step();
        end
        en = 1'b0;
        data_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; data_i = 1'b0; frame_ready_i = 1'b0;
        repeat (3) step();
        total++; if (frame_valid_o !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", frame_valid_o); bad++; end
        total++; if (err_o !== 1'b0) begin $display("FAIL reset_err got=%b exp=0", err_o); bad++; end
        total++; if (err_code_o !== 2'b00) begin $display("FAIL reset_code got=%b exp=00", err_code_o); bad++; end
        total++; if (busy_o !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", busy_o); bad++; end
        total++; if (opcode_o !== 4'h0) begin $display("FAIL reset_opcode got=%h exp=0", opcode_o); bad++; end
        total++; if (header_o !== 64'h0) begin $display("FAIL reset_header got=%h exp=0", header_o); bad++; end
        total++; if (payload_o !== 128'h0) begin $display("FAIL reset_payload got=%h exp=0", payload_o); bad++; end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [63:0]  hdr;
        logic [127:0] pay;
        int e0, v0, x0;
        hdr = 64'h0123_4567_89AB_CDE0;
        pay = {16{8'hA5}};
        e0 = err_seen; v0 = valid_seen; x0 = xfer_seen;
        frame_ready_i = 1'b1;
        drive_frame({pay, hdr}, 192);
        total++; if (busy_o !== 1'b1) begin $display("FAIL basic_busy_shift got=%b exp=1", busy_o); bad++; end
        total++; if (frame_valid_o !== 1'b0) begin $display("FAIL basic_valid_early got=%b exp=0", frame_valid_o); bad++; end
        step();
        total++; if (frame_valid_o !== 1'b1) begin $display("FAIL basic_valid got=%b exp=1", frame_valid_o); bad++; end
        total++; if (opcode_o !== 4'b0000) begin $display("FAIL basic_opcode got=%h exp=0", opcode_o); bad++; end
        total++; if (header_o !== hdr) begin $display("FAIL basic_header got=%h exp=%h", header_o, hdr); bad++; end
        total++; if (payload_o !== pay) begin $display("FAIL basic_payload got=%h exp=%h", payload_o, pay); bad++; end
        step();
        total++; if (frame_valid_o !== 1'b0) begin $display("FAIL basic_valid_after got=%b exp=0", frame_valid_o); bad++; end
        total++; if (busy_o !== 1'b0) begin $display("FAIL basic_busy_after got=%b exp=0", busy_o); bad++; end
        total++; if (valid_seen - v0 !== 1) begin $display("FAIL basic_valid_cycles got=%0d exp=1", valid_seen - v0); bad++; end
        total++; if (xfer_seen - x0 !== 1) begin $display("FAIL basic_xfers got=%0d exp=1", xfer_seen - x0); bad++; end
        total++; if (err_seen - e0 !== 0) begin $display("FAIL basic_err got=%0d exp=0", err_seen - e0); bad++; end
    endtask

    task automatic test_backpressure();
        logic [63:0]  hdr;
        logic [127:0] pay;
        int v0, x0, e0;
        hdr = 64'hFEDC_BA98_7654_3211;
        pay = {4{32'h1357_9BDF}};
        v0 = valid_seen; x0 = xfer_seen; e0 = err_seen;
        frame_ready_i = 1'b0;
        drive_frame({pay, hdr}, 192);
        step();
        for (int k = 0; k < 10; k++) begin
            total++; if (frame_valid_o !== 1'b1) begin $display("FAIL bp_valid[%0d] got=%b exp=1", k, frame_valid_o); bad++; end
            total++; if (opcode_o !== 4'b0001) begin $display("FAIL bp_opcode[%0d] got=%h exp=1", k, opcode_o); bad++; end
            total++; if (header_o !== hdr) begin $display("FAIL bp_header[%0d] got=%h exp=%h", k, header_o, hdr); bad++; end
            total++; if (payload_o !== pay) begin $display("FAIL bp_payload[%0d] got=%h exp=%h", k, payload_o, pay); bad++; end
            step();
        end
        frame_ready_i = 1'b1;
        step();
        total++; if (frame_valid_o !== 1'b0) begin $display("FAIL bp_valid_after got=%b exp=0", frame_valid_o); bad++; end
        total++; if (valid_seen - v0 !== 11) begin $display("FAIL bp_valid_cycles got=%0d exp=11", valid_seen - v0); bad++; end
        total++; if (xfer_seen - x0 !== 1) begin $display("FAIL bp_xfers got=%0d exp=1", xfer_seen - x0); bad++; end
        total++; if (err_seen - e0 !== 0) begin $display("FAIL bp_err got=%0d exp=0", err_seen - e0); bad++; end
    endtask

    task automatic test_short();
        int e0, v0;
        e0 = err_seen; v0 = valid_seen;
        drive_frame({128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 64'h0}, 100);
        step();
        total++; if (err_o !== 1'b1) begin $display("FAIL short_err got=%b exp=1", err_o); bad++; end
        total++; if (err_code_o !== 2'b01) begin $display("FAIL short_code got=%b exp=01", err_code_o); bad++; end
        total++; if (busy_o !== 1'b0) begin $display("FAIL short_busy got=%b exp=0", busy_o); bad++; end
        step();
        total++; if (err_o !== 1'b0) begin $display("FAIL short_err_width got=%b exp=0", err_o); bad++; end
        total++; if (err_seen - e0 !== 1) begin $display("FAIL short_err_count got=%0d exp=1", err_seen - e0); bad++; end
        total++; if (valid_seen - v0 !== 0) begin $display("FAIL short_valid got=%0d exp=0", valid_seen - v0); bad++; end
    endtask

    task automatic test_opcode();
        int e0, v0;
        e0 = err_seen; v0 = valid_seen;
        drive_frame({{16{8'h3C}}, 64'h0000_0000_0000_0005}, 192);
        step();
        total++; if (err_o !== 1'b1) begin $display("FAIL opc_err got=%b exp=1", err_o); bad++; end
        total++; if (err_code_o !== 2'b11) begin $display("FAIL opc_code got=%b exp=11", err_code_o); bad++; end
        total++; if (frame_valid_o !== 1'b0) begin $display("FAIL opc_valid got=%b exp=0", frame_valid_o); bad++; end
        step();
        total++; if (busy_o !== 1'b0) begin $display("FAIL opc_busy got=%b exp=0", busy_o); bad++; end
        total++; if (err_seen - e0 !== 1) begin $display("FAIL opc_err_count got=%0d exp=1", err_seen - e0); bad++; end
        total++; if (valid_seen - v0 !== 0) begin $display("FAIL opc_valid_count got=%0d exp=0", valid_seen - v0); bad++; end
    endtask

    task automatic test_back_to_back();
        logic [63:0]  hdr_a, hdr_b;
        logic [127:0] pay_a, pay_b;
        int e0, x0;
        hdr_a = 64'hAAAA_5555_0F0F_F0F0;
        pay_a = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        hdr_b = 64'h8000_0000_1234_5671;
        pay_b = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
        frame_ready_i = 1'b0;
        drive_frame({pay_a, hdr_a}, 192);
        step();
        step();
        step();
        e0 = err_seen;
        en = 1'b1;
        repeat (5) begin
            data_i = 1'($urandom_range(0, 1));
            step();
        end
        en = 1'b0;
        data_i = 1'b0;
        step();
        total++; if (err_seen - e0 !== 1) begin $display("FAIL ovr_err_count got=%0d exp=1", err_seen - e0); bad++; end
        total++; if (err_code_o !== 2'b10) begin $display("FAIL ovr_code got=%b exp=10", err_code_o); bad++; end
        total++; if (frame_valid_o !== 1'b1) begin $display("FAIL ovr_valid got=%b exp=1", frame_valid_o); bad++; end
        total++; if (header_o !== hdr_a) begin $display("FAIL ovr_header got=%h exp=%h", header_o, hdr_a); bad++; end
        total++; if (payload_o !== pay_a) begin $display("FAIL ovr_payload got=%h exp=%h", payload_o, pay_a); bad++; end
        step();
        x0 = xfer_seen;
        frame_ready_i = 1'b1;
        drive_frame({pay_b, hdr_b}, 192);
        step();
        total++; if (frame_valid_o !== 1'b1) begin $display("FAIL b2b_valid got=%b exp=1", frame_valid_o); bad++; end
        total++; if (opcode_o !== 4'b0001) begin $display("FAIL b2b_opcode got=%h exp=1", opcode_o); bad++; end
        total++; if (header_o !== hdr_b) begin $display("FAIL b2b_header got=%h exp=%h", header_o, hdr_b); bad++; end
        total++; if (payload_o !== pay_b) begin $display("FAIL b2b_payload got=%h exp=%h", payload_o, pay_b); bad++; end
        step();
        total++; if (xfer_seen - x0 !== 2) begin $display("FAIL b2b_xfers got=%0d exp=2", xfer_seen - x0); bad++; end
        total++; if (err_seen - e0 !== 1) begin $display("FAIL b2b_err_count got=%0d exp=1", err_seen - e0); bad++; end
        total++; if (frame_valid_o !== 1'b0) begin $display("FAIL b2b_valid_after got=%b exp=0", frame_valid_o); bad++; end
    endtask

    task automatic test_reset_mid();
        logic [191:0] f;
        logic [63:0]  hdr_c;
        logic [127:0] pay_c;
        int e0, v0;
        f = {{8{16'h9C63}}, 64'h0000_0000_0000_0001};
        hdr_c = 64'h1357_2468_ACE0_BDF0;
        pay_c = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
        e0 = err_seen;
        frame_ready_i = 1'b1;
        en = 1'b1;
        data_i = 1'b0;
        step();
        step();
        for (int i = 0; i < 150; i++) begin
            data_i = f[i];
            step();
        end
        rst_n = 1'b0;
        step();
        total++; if (frame_valid_o !== 1'b0) begin $display("FAIL rmid_valid got=%b exp=0", frame_valid_o); bad++; end
        total++; if (busy_o !== 1'b0) begin $display("FAIL rmid_busy got=%b exp=0", busy_o); bad++; end
        total++; if (err_o !== 1'b0) begin $display("FAIL rmid_err got=%b exp=0", err_o); bad++; end
        total++; if (err_code_o !== 2'b00) begin $display("FAIL rmid_code got=%b exp=00", err_code_o); bad++; end
        total++; if (opcode_o !== 4'h0) begin $display("FAIL rmid_opcode got=%h exp=0", opcode_o); bad++; end
        total++; if (header_o !== 64'h0) begin $display("FAIL rmid_header got=%h exp=0", header_o); bad++; end
        total++; if (payload_o !== 128'h0) begin $display("FAIL rmid_payload got=%h exp=0", payload_o); bad++; end
        rst_n = 1'b1;
        v0 = valid_seen;
        for (int i = 151; i < 192; i++) begin
            data_i = f[i];
            step();
        end
        en = 1'b0;
        data_i = 1'b0;
        step();
        step();
        total++; if (valid_seen - v0 !== 0) begin $display("FAIL rmid_tail_valid got=%0d exp=0", valid_seen - v0); bad++; end
        total++; if (busy_o !== 1'b0) begin $display("FAIL rmid_tail_busy got=%b exp=0", busy_o); bad++; end
        drive_frame({pay_c, hdr_c}, 192);
        step();
        total++; if (frame_valid_o !== 1'b1) begin $display("FAIL rmid_next_valid got=%b exp=1", frame_valid_o); bad++; end
        total++; if (header_o !== hdr_c) begin $display("FAIL rmid_next_header got=%h exp=%h", header_o, hdr_c); bad++; end
        total++; if (payload_o !== pay_c) begin $display("FAIL rmid_next_payload got=%h exp=%h", payload_o, pay_c); bad++; end
        step();
        total++; if (err_seen - e0 !== 0) begin $display("FAIL rmid_err_count got=%0d exp=0", err_seen - e0); bad++; end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_short();
        test_opcode();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pmu_frame_rx.md
PMU_FRAME_RX -- requirements
Module: pmu_frame_rx

Interface
REQ-001 Parameter KEY_LENGTH, default 128, payload width in bits.
REQ-002 Parameter HEADER_LENGTH, default 64, header width in bits; frame length FRAME_LENGTH = HEADER_LENGTH + KEY_LENGTH (192).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 en  input  1  frame enable from the host serial link; high for the whole frame.
REQ-006 data_i  input  1  serial frame data, LSB first.
REQ-007 frame_ready_i  input  1  downstream pmu core accepts the held frame.
REQ-008 frame_valid_o  output  1  held frame available.
REQ-009 opcode_o  output  4  frame opcode, equal to header bits [3:0].
REQ-010 header_o  output  HEADER_LENGTH  received header.
REQ-011 payload_o  output  KEY_LENGTH  received payload (encoded key or encoded bitstream).
REQ-012 err_o  output  1  one-cycle error pulse.
REQ-013 err_code_o  output  2  cause of the most recent error; held until the next error.
REQ-014 busy_o  output  1  high in SHIFT and HOLD.

Function
REQ-015 States: IDLE, SYNC, SHIFT, HOLD.
REQ-016 IDLE: en==1 sampled -> SYNC; data_i is ignored on that edge.
REQ-017 SYNC: one discarded cycle; on the next edge go to SHIFT if en==1, else back to IDLE with err_code 01 (short).
REQ-018 SHIFT: each edge with en==1 stores data_i at bit index cnt (cnt 0..191); bits 0..63 form header_o and bits 64..191 form payload_o.
REQ-019 cnt is 8 bits wide and saturates at FRAME_LENGTH; bits sampled after cnt==192 (trailing bits) are dropped without error.
REQ-020 SHIFT, first edge with en==0 and cnt==192: go to HOLD; frame_valid_o is high from that edge onward, a latency of one edge after en falls.
REQ-021 SHIFT, en==0 with cnt<192: go to IDLE, pulse err_o, err_code_o=01 (short frame); the partial frame is discarded.
REQ-022 Opcode check on entering HOLD: only 0000 (load key) and 0001 (load memory) are legal; any other opcode goes to IDLE with err_code_o=11 (illegal opcode), and frame_valid_o never rises.
REQ-023 HOLD: frame_valid_o, opcode_o, header_o and payload_o stay stable until the cycle in which frame_valid_o and frame_ready_i are both high; the transfer completes at that edge.
REQ-024 HOLD, en==1 sampled before the transfer completes: the incoming bits are dropped, err_o pulses, err_code_o=10 (overrun), and the held frame is kept.
REQ-025 Transfer-completion edge with en==1: go directly to SYNC; this edge is the new frame's sync cycle, and no overrun is reported.
REQ-026 Transfer-completion edge with en==0: go to IDLE.
REQ-027 err_o pulses for exactly one cycle per error event and never in the same cycle as a transfer.

Reset
REQ-028 With rst_n==0 at an edge: state=IDLE, cnt=0, frame_valid_o=0, err_o=0, err_code_o=00, busy_o=0, opcode_o=0, header_o=0, payload_o=0.
REQ-029 Reset mid-frame or mid-HOLD discards the frame without an error pulse; after rst_n returns high, en must be sampled low once before a new frame is accepted.

Structure
REQ-030 Package pmu_pkg holds KEY_LENGTH, HEADER_LENGTH, FRAME_LENGTH, the opcode constants (OP_LOAD_KEY=0000, OP_LOAD_MEM=0001), the error codes (ERR_SHORT=01, ERR_OVERRUN=10, ERR_OPCODE=11) and the state enumeration.
REQ-031 The serial-in/parallel-out shift register with its saturating counter is one sub-module, pmu_sipo; the FSM, opcode check and handshake live in pmu_frame_rx.

Verification
REQ-032 Reset, en high for 1+192+1 cycles carrying header 0x...0000 and payload 0xA5 repeated, frame_ready_i=1 -> frame_valid_o high for one cycle after en falls, opcode_o=0000, payload_o=0xA5A5..., no err_o.
REQ-033 Same frame with opcode 0001 and frame_ready_i held low for 10 cycles -> frame_valid_o high for 10 cycles, outputs stable, transfer on cycle 11.
REQ-034 en high for a 100-bit frame -> err_o single pulse, err_code_o=01, frame_valid_o stays 0, state IDLE.
REQ-035 Frame with opcode 0101 -> err_code_o=11, no frame_valid_o.
REQ-036 While HOLD with frame_ready_i=0, en pulsed high for 5 cycles -> err_code_o=10, held payload unchanged; then frame_ready_i=1 with en high on the same edge -> transfer plus a new frame starts, and the second frame is received correctly.
REQ-037 rst_n low for 1 cycle at bit 150 of a frame -> all outputs at reset values, no err_o; the next full frame is received correctly.
